// File: rtl/pfr_reset_gate_pkg.sv
// rtl/pfr_reset_gate_pkg.sv - shared state encoding and counter sizing for the reset release gate
package pfr_reset_gate_pkg;

  typedef enum logic [1:0] {
    HOLD_MIN = 2'b00,
    WAIT     = 2'b01,
    DLY      = 2'b10,
    REL      = 2'b11
  } rst_gate_state_t;

  // One counter serves both the hold and the settle phase, so size it for the larger bound.
  function automatic int calc_cnt_w(input int min_assert, input int release_dly);
    int m;
    m = (min_assert > release_dly) ? min_assert : release_dly;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_release_channel.sv
// rtl/reset_release_channel.sv - one reset domain: min-assert hold, authorized settle delay, registered release
module reset_release_channel
  import pfr_reset_gate_pkg::*;
#(
  parameter int MIN_ASSERT_CYCLES  = 200,
  parameter int RELEASE_DLY_CYCLES = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rel_req,
  input  logic       allow,
  input  logic       force_hold,
  output logic       rst_n,
  output logic       rel_pulse,
  output logic [1:0] state
);

  localparam int CNT_W = calc_cnt_w(MIN_ASSERT_CYCLES, RELEASE_DLY_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RELEASE_DLY_CYCLES - 1);

  rst_gate_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_n_q, pulse_q;
  logic             go;

  assign go = rel_req & allow & ~force_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HOLD_MIN;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= (state_d == REL);
      pulse_q <= (state_d == REL) && (state_q != REL);
    end
  end

  // Counter is cleared on every transition so it never needs to wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD_MIN: begin
        if (cnt_q == MIN_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (go) begin
          state_d = DLY;
          cnt_d   = '0;
        end
      end
      DLY: begin
        // Reset was never released here, so a dropped go only restarts the settle delay.
        if (!go) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REL: begin
        if (!go) begin
          state_d = HOLD_MIN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HOLD_MIN;
        cnt_d   = '0;
      end
    endcase
  end

  assign rst_n     = rst_n_q;
  assign rel_pulse = pulse_q;
  assign state     = state_q;

endmodule

// File: rtl/pfr_reset_release_gate.sv
// rtl/pfr_reset_release_gate.sv - gates RSMRST and BMC SRST release on PFR authorization
module pfr_reset_release_gate #(
  parameter int MIN_ASSERT_CYCLES  = 200,
  parameter int RELEASE_DLY_CYCLES = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_pch_rel_req,
  input  logic       i_bmc_rel_req,
  input  logic       i_pch_allow,
  input  logic       i_bmc_allow,
  input  logic       i_force_hold,
  output logic       o_rst_rsmrst_n,
  output logic       o_rst_srst_bmc_n,
  output logic       o_pch_rel_pulse,
  output logic       o_bmc_rel_pulse,
  output logic [1:0] o_pch_state,
  output logic [1:0] o_bmc_state
);

  reset_release_channel #(
    .MIN_ASSERT_CYCLES (MIN_ASSERT_CYCLES),
    .RELEASE_DLY_CYCLES(RELEASE_DLY_CYCLES)
  ) u_pch_chan (
    .clk       (clk),
    .resetn    (resetn),
    .rel_req   (i_pch_rel_req),
    .allow     (i_pch_allow),
    .force_hold(i_force_hold),
    .rst_n     (o_rst_rsmrst_n),
    .rel_pulse (o_pch_rel_pulse),
    .state     (o_pch_state)
  );

  reset_release_channel #(
    .MIN_ASSERT_CYCLES (MIN_ASSERT_CYCLES),
    .RELEASE_DLY_CYCLES(RELEASE_DLY_CYCLES)
  ) u_bmc_chan (
    .clk       (clk),
    .resetn    (resetn),
    .rel_req   (i_bmc_rel_req),
    .allow     (i_bmc_allow),
    .force_hold(i_force_hold),
    .rst_n     (o_rst_srst_bmc_n),
    .rel_pulse (o_bmc_rel_pulse),
    .state     (o_bmc_state)
  );

endmodule

// File: tb/tb_pfr_reset_release_gate.sv
// tb/tb_pfr_reset_release_gate.sv - directed vector bench for the reset release gate
module tb_pfr_reset_release_gate;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pch_req, bmc_req, pch_allow, bmc_allow, force_hold;
  logic       rst_rsmrst_n, rst_srst_bmc_n, pch_pulse, bmc_pulse;
  logic [1:0] pch_state, bmc_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       preq, pall, breq, ball, frc;
    logic [1:0] ps, bs;
    logic       pp, bp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pfr_reset_release_gate #(
    .MIN_ASSERT_CYCLES (4),
    .RELEASE_DLY_CYCLES(3)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .i_pch_rel_req   (pch_req),
    .i_bmc_rel_req   (bmc_req),
    .i_pch_allow     (pch_allow),
    .i_bmc_allow     (bmc_allow),
    .i_force_hold    (force_hold),
    .o_rst_rsmrst_n  (rst_rsmrst_n),
    .o_rst_srst_bmc_n(rst_srst_bmc_n),
    .o_pch_rel_pulse (pch_pulse),
    .o_bmc_rel_pulse (bmc_pulse),
    .o_pch_state     (pch_state),
    .o_bmc_state     (bmc_state)
  );

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected rst_n comes from the expected state: the pin is high exactly in REL.
  task automatic chk_all(input string tag, input logic [1:0] ps, input logic [1:0] bs,
                         input logic pp, input logic bp);
    chk({tag, "_pch_state"}, pch_state, ps);
    chk({tag, "_bmc_state"}, bmc_state, bs);
    chk({tag, "_pch_rst"}, {1'b0, rst_rsmrst_n}, {1'b0, ps == 2'b11});
    chk({tag, "_bmc_rst"}, {1'b0, rst_srst_bmc_n}, {1'b0, bs == 2'b11});
    chk({tag, "_pch_pulse"}, {1'b0, pch_pulse}, {1'b0, pp});
    chk({tag, "_bmc_pulse"}, {1'b0, bmc_pulse}, {1'b0, bp});
  endtask

  task automatic add(input logic preq, input logic pall, input logic breq, input logic ball,
                     input logic frc, input logic [1:0] ps, input logic [1:0] bs,
                     input logic pp, input logic bp);
    vec_t v;
    v.preq = preq; v.pall = pall; v.breq = breq; v.ball = ball; v.frc = frc;
    v.ps = ps; v.bs = bs; v.pp = pp; v.bp = bp;
    tbl.push_back(v);
  endtask

  initial begin
    // Cold release: 4 cycles HOLD_MIN, 1 WAIT, 3 DLY, release at edge 8
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    add(1, 1, 1, 1, 0, 2'b01, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b10, 2'b10, 0, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 1, 1);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 0, 0);
    // Independence: BMC request drop, PCH untouched
    add(1, 1, 0, 1, 0, 2'b11, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b11, 2'b00, 0, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b11, 2'b10, 0, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 0, 1);
    // Recovery hold, then requests rise under hold (hold wins)
    add(1, 1, 1, 1, 1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    add(0, 1, 0, 1, 0, 2'b01, 2'b01, 0, 0);
    add(1, 1, 1, 1, 1, 2'b01, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b10, 2'b10, 0, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 1, 1);
    // Gated authorization on PCH
    for (int i = 0; i < 4; i++) add(1, 0, 1, 1, 0, 2'b00, 2'b11, 0, 0);
    for (int i = 0; i < 50; i++) add(1, 0, 1, 1, 0, 2'b01, 2'b11, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b10, 2'b11, 0, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 1, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 0, 0);
    // Glitch in DLY (PCH at cnt=1) and allow loss on the completing edge (BMC at cnt=2)
    add(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    add(1, 1, 1, 1, 0, 2'b01, 2'b01, 0, 0);
    add(1, 1, 1, 1, 0, 2'b10, 2'b10, 0, 0);
    add(1, 1, 1, 1, 0, 2'b10, 2'b10, 0, 0);
    add(1, 0, 1, 1, 0, 2'b01, 2'b10, 0, 0);
    add(1, 1, 1, 0, 0, 2'b10, 2'b01, 0, 0);
    add(1, 1, 1, 1, 0, 2'b10, 2'b10, 0, 0);
    add(1, 1, 1, 1, 0, 2'b10, 2'b10, 0, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b10, 1, 0);
    add(1, 1, 1, 1, 0, 2'b11, 2'b11, 0, 1);

    resetn = 1'b0;
    pch_req = 1'b0; bmc_req = 1'b0; pch_allow = 1'b0; bmc_allow = 1'b0; force_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'b00, 2'b00, 0, 0);

    resetn = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      pch_req    = tbl[i].preq;
      pch_allow  = tbl[i].pall;
      bmc_req    = tbl[i].breq;
      bmc_allow  = tbl[i].ball;
      force_hold = tbl[i].frc;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), tbl[i].ps, tbl[i].bs, tbl[i].pp, tbl[i].bp);
    end

    // Async reset while released: pins drop between edges
    #3 resetn = 1'b0;
    #1 chk_all("async_rel", 2'b00, 2'b00, 0, 0);
    @(negedge clk) resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk_all("pre_async_dly", 2'b10, 2'b10, 0, 0);
    // Async reset mid-DLY, then no pulse while climbing out of reset
    #2 resetn = 1'b0;
    #1 chk_all("async_dly", 2'b00, 2'b00, 0, 0);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk_all($sformatf("post_async%0d", i), 2'b00, 2'b00, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pfr_reset_release_gate.md
Name: pfr_reset_release_gate

Overview:
- Sits between the main platform sequencer and the board pins RST_RSMRST_PLD_R_N and RST_SRST_BMC_PLD_R_N.
- The sequencer only requests reset release (RST_RSMRST_PLD_R_N_REQ, RST_SRST_BMC_PLD_R_N_REQ). This block releases each reset only when PFR firmware has authorized that domain.
- Enforces a minimum reset-assert time and a release settle delay per domain.
- Re-asserts immediately on request drop, authorization loss or recovery hold.

Parameters:
- MIN_ASSERT_CYCLES, 200, minimum cycles a reset is held after any (re)assertion; must be >=1.
- RELEASE_DLY_CYCLES, 20, cycles the release condition must hold continuously before the reset deasserts; must be >=1.
- CNT_W, $clog2(max(MIN_ASSERT_CYCLES,RELEASE_DLY_CYCLES)+1), localparam, shared counter width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- i_pch_rel_req  in  1  sequencer request to release RSMRST (1 = release)
- i_bmc_rel_req  in  1  sequencer request to release BMC SRST
- i_pch_allow  in  1  PFR authorization for PCH domain
- i_bmc_allow  in  1  PFR authorization for BMC domain
- i_force_hold  in  1  global recovery hold; forces both resets asserted
- o_rst_rsmrst_n  out  1  registered RSMRST to board (0 = in reset)
- o_rst_srst_bmc_n  out  1  registered BMC SRST to board
- o_pch_rel_pulse  out  1  one-cycle pulse when RSMRST deasserts
- o_bmc_rel_pulse  out  1  one-cycle pulse when BMC SRST deasserts
- o_pch_state  out  2  PCH channel FSM state
- o_bmc_state  out  2  BMC channel FSM state

Behaviour:
- The two channels are identical and fully independent.
- Per channel, go = req & allow & ~i_force_hold, sampled at each clk edge. Inputs are already synchronous to clk; no synchronizers are inside this block.
- Reset (resetn=0, asynchronous):
  - state = HOLD_MIN (2'b00), cnt = 0
  - rst_n outputs = 0, pulses = 0
- HOLD_MIN (00):
  - cnt increments every cycle regardless of go.
  - When cnt == MIN_ASSERT_CYCLES-1: go to WAIT, cnt = 0.
  - i_force_hold has no extra effect here.
- WAIT (01):
  - If go: go to DLY, cnt = 0.
  - Otherwise stay in WAIT; the minimum-assert time is already satisfied and is not re-armed.
- DLY (10):
  - If ~go: go to WAIT, cnt = 0. Reset was never released, so HOLD_MIN is not re-entered.
  - Else if cnt == RELEASE_DLY_CYCLES-1: go to REL.
  - Else cnt++.
- REL (11):
  - If ~go: go to HOLD_MIN, cnt = 0.
- rst_n is registered and equals 1 iff the next state is REL. rst_n and state change on the same edge.
- rel_pulse = 1 for exactly the one cycle following the edge that enters REL.
- Latency:
  - Release: the first edge sampling go=1 while in WAIT is edge k; rst_n rises at edge k+RELEASE_DLY_CYCLES.
  - Re-assert: rst_n falls at the first edge sampling go=0 while in REL (1 cycle).
- Minimum reset low time after any assertion is MIN_ASSERT_CYCLES+1+RELEASE_DLY_CYCLES cycles.
- Glitch rule: a one-cycle drop of go during DLY restarts the full delay. A one-cycle drop in REL forces a full HOLD_MIN cycle.
- Simultaneous events:
  - force_hold with req rising: hold wins.
  - allow dropping on the same edge DLY would complete: go to WAIT, no release, no pulse.
- Mid-operation resetn assertion returns both channels to HOLD_MIN with rst_n=0 immediately (asynchronous). No pulse is emitted.
- Counters never wrap: cnt is cleared on every transition and only counts in HOLD_MIN/DLY up to the bound.

Decomposition:
- Package pfr_reset_gate_pkg holds:
  - enum rst_gate_state_t {HOLD_MIN=2'b00, WAIT=2'b01, DLY=2'b10, REL=2'b11}
  - a function computing CNT_W from the two parameters.
- Sub-module reset_release_channel (FSM + counter + registered rst_n + pulse).
- Top instantiates the sub-module twice and fans out i_force_hold to both.

Test Plan (bench with MIN_ASSERT_CYCLES=4, RELEASE_DLY_CYCLES=3):
- Cold release: deassert resetn with req=allow=1 from cycle 0 -> state 00 for 4 cycles, 01 for 1, 10 for 3; o_rst_rsmrst_n rises at cycle 8; o_pch_rel_pulse high for exactly 1 cycle; BMC identical.
- Gated authorization: req=1, allow=0 for 50 cycles, then allow=1 at edge k -> rst_n stays 0 until edge k+3, then 1.
- Glitch in DLY: allow drops for 1 cycle at DLY cnt=1 -> returns to WAIT; release occurs 3 cycles after allow returns; no early pulse.
- Recovery hold: both released, i_force_hold=1 for 1 cycle -> both rst_n=0 next cycle; with go restored, both stay low for >=8 cycles and then release together.
- Independence: drop i_bmc_rel_req only -> o_rst_srst_bmc_n falls, o_rst_rsmrst_n stays 1, o_pch_state stays 11.
- Async reset mid-DLY: pull resetn low between edges -> both outputs 0 and states 00 immediately, no pulse on exit.
